// File: rtl/onehot_scan_encoder.sv
// Latches a WIDTH-bit request vector and emits the index of each set bit, one per handshake.
// Optional macro ONEHOT_SCAN_MSB_FIRST_EN switches emission order to highest index first.
module onehot_scan_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err,
  output logic [IDX_W:0]   pend_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] pend_r;
  logic [WIDTH-1:0] pend_nxt_s;
  logic             zero_err_r;
  logic             zero_nxt_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W:0]   cnt_s;
  logic [WIDTH-1:0] sel_mask_s;

`ifdef ONEHOT_SCAN_MSB_FIRST_EN
  function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = {(IDX_W+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Index selection and population count from the registered pending set only
  always_comb begin
    sel_idx_s  = pick_index(pend_r);
    cnt_s      = popcount(pend_r);
    sel_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << sel_idx_s;
  end

  // Next-state, next pending set and zero-vector flag
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    zero_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != {WIDTH{1'b0}}) begin
            pend_nxt_s  = in_vec;
            state_nxt_s = SCAN;
          end else begin
            zero_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_nxt_s = pend_r & ~sel_mask_s;
          if (cnt_s == {{IDX_W{1'b0}}, 1'b1}) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SCAN;
          end
        end else begin
          state_nxt_s = SCAN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pend_nxt_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, pending set and error pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pend_r     <= {WIDTH{1'b0}};
      zero_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pend_r     <= pend_nxt_s;
      zero_err_r <= zero_nxt_s;
    end
  end

  // Output decode; IDLE forces the index fields to their reset values
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_idx   = {IDX_W{1'b0}};
    out_last  = 1'b0;
    pend_cnt  = {(IDX_W+1){1'b0}};
    zero_err  = zero_err_r;
    if (state_r == SCAN) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
      out_idx   = sel_idx_s;
      out_last  = (cnt_s == {{IDX_W{1'b0}}, 1'b1});
      pend_cnt  = cnt_s;
    end else begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder at WIDTH=8 and WIDTH=5; honours ONEHOT_SCAN_MSB_FIRST_EN.
module tb_onehot_scan_encoder;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, zero_err;
  logic [7:0] in_vec;
  logic [2:0] out_idx;
  logic [3:0] pend_cnt;

  logic       in_valid5, in_ready5, out_valid5, out_ready5, out_last5, zero_err5;
  logic [4:0] in_vec5;
  logic [2:0] out_idx5;
  logic [3:0] pend_cnt5;

  int vectors = 0;
  int miscompares = 0;
  int beats;

  onehot_scan_encoder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .zero_err(zero_err), .pend_cnt(pend_cnt)
  );

  onehot_scan_encoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_vec(in_vec5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_idx(out_idx5), .out_last(out_last5),
    .zero_err(zero_err5), .pend_cnt(pend_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    in_vec   = ~v;
  endtask

  task automatic beat8(input string tag, input int idx, input int last, input int cnt);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_idx"},   {29'd0, out_idx}, idx);
    chk({tag, "_last"},  {31'd0, out_last}, last);
    chk({tag, "_cnt"},   {28'd0, pend_cnt}, cnt);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    in_valid5 = 1'b0; in_vec5 = 5'h00; out_ready5 = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx",   {29'd0, out_idx}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    chk("rst_zero_err",  {31'd0, zero_err}, 32'd0);
    chk("rst_pend_cnt",  {28'd0, pend_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // single bit 4
    out_ready = 1'b1;
    accept8(8'b0001_0000);
    beat8("single", 4, 1, 1);
    chk("single_in_ready_busy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("single_done_valid", {31'd0, out_valid}, 32'd0);
    chk("single_in_ready",   {31'd0, in_ready}, 32'd1);

    // three bits, back-to-back beats
    accept8(8'b1000_0101);
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
    beat8("multi0", 7, 0, 3); tick();
    beat8("multi1", 2, 0, 2); tick();
    beat8("multi2", 0, 1, 1); tick();
`else
    beat8("multi0", 0, 0, 3); tick();
    beat8("multi1", 2, 0, 2); tick();
    beat8("multi2", 7, 1, 1); tick();
`endif
    chk("multi_done_valid", {31'd0, out_valid}, 32'd0);

    // all-zero vector
    accept8(8'h00);
    chk("zero_err_pulse", {31'd0, zero_err}, 32'd1);
    chk("zero_out_valid", {31'd0, out_valid}, 32'd0);
    chk("zero_in_ready",  {31'd0, in_ready}, 32'd1);
    tick();
    chk("zero_err_clear",  {31'd0, zero_err}, 32'd0);
    chk("zero_out_valid2", {31'd0, out_valid}, 32'd0);

    // all-ones with stalls: out_ready 1,0,0 repeating
    out_ready = 1'b0;
    accept8(8'hFF);
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      out_ready = (c % 3 == 0);
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
      beat8("ff", 7 - beats, (beats == 7) ? 1 : 0, 8 - beats);
`else
      beat8("ff", beats, (beats == 7) ? 1 : 0, 8 - beats);
`endif
      tick();
      if (out_ready) beats++;
    end
    chk("ff_done_valid", {31'd0, out_valid}, 32'd0);
    chk("ff_in_ready",   {31'd0, in_ready}, 32'd1);

    // reset mid-scan
    out_ready = 1'b1;
    accept8(8'b0110_0110);
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
    beat8("mid0", 6, 0, 4); tick();
    beat8("mid1", 5, 0, 3);
`else
    beat8("mid0", 1, 0, 4); tick();
    beat8("mid1", 2, 0, 3);
`endif
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_idx",   {29'd0, out_idx}, 32'd0);
    chk("arst_pend_cnt",  {28'd0, pend_cnt}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    accept8(8'b0000_0010);
    beat8("after_rst", 1, 1, 1);
    tick();
    chk("after_rst_done", {31'd0, out_valid}, 32'd0);

    // WIDTH=5 instance
    out_ready5 = 1'b1;
    in_valid5 = 1'b1; in_vec5 = 5'b10001;
    tick();
    in_valid5 = 1'b0; in_vec5 = 5'b01110;
    chk("w5_valid0", {31'd0, out_valid5}, 32'd1);
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
    chk("w5_idx0", {29'd0, out_idx5}, 32'd4);
`else
    chk("w5_idx0", {29'd0, out_idx5}, 32'd0);
`endif
    chk("w5_last0", {31'd0, out_last5}, 32'd0);
    chk("w5_cnt0",  {28'd0, pend_cnt5}, 32'd2);
    chk("w5_range0", {31'd0, (out_idx5 <= 3'd4)}, 32'd1);
    tick();
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
    chk("w5_idx1", {29'd0, out_idx5}, 32'd0);
`else
    chk("w5_idx1", {29'd0, out_idx5}, 32'd4);
`endif
    chk("w5_last1", {31'd0, out_last5}, 32'd1);
    chk("w5_cnt1",  {28'd0, pend_cnt5}, 32'd1);
    chk("w5_range1", {31'd0, (out_idx5 <= 3'd4)}, 32'd1);
    tick();
    chk("w5_done", {31'd0, out_valid5}, 32'd0);
    chk("w5_in_ready", {31'd0, in_ready5}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
